// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type, default sizes and width helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF      = 4;
    localparam int DWIDTH_DEF    = 16;
    localparam int DEPTH_DEF     = 8;
    localparam int MAX_BURST_DEF = 4;

    // Index width that stays legal (>=1) even for a single-entry range
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Credits must represent 0..DEPTH inclusive
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder, scan begins at start
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int GW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   start,
    output logic [GW-1:0]   gnt_idx,
    output logic            any
);

    localparam int SW = GW + 1;

    logic [SW-1:0] sum;
    logic [GW-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, start} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[GW-1:0];
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port, credit-based flow control
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_din,
    input  logic                     fifo_pop,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   credits,
    output logic                     err
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = idx_width(MAX_BURST);
    localparam int CW = credit_width(DEPTH);

    localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);

    arb_state_t     state;
    logic [GW-1:0]  rr_ptr;
    logic [BW-1:0]  beat_cnt;
    logic [GW-1:0]  pick_idx;
    logic           pick_any;
    logic           have_credit;
    logic           cur_valid;
    logic           cur_last;
    logic           burst_end;
    logic           pop_ok;
    logic [CW-1:0]  credits_next;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req     (req_valid),
        .start   (rr_ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign have_credit = (credits != '0);
    assign busy        = (state == BURST);
    assign cur_valid   = req_valid[grant_id];
    assign cur_last    = req_last[grant_id];
    assign fifo_wr_en  = busy && have_credit && cur_valid;
    assign fifo_din    = req_data[int'(grant_id)*DWIDTH +: DWIDTH];
    assign burst_end   = fifo_wr_en && (cur_last || (beat_cnt == LAST_BEAT));

    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = busy && have_credit;
    end

    // A pop while the FIFO is already empty by our count is bogus; drop it
    assign pop_ok       = fifo_pop && (credits != CRED_FULL);
    assign credits_next = credits - CW'(fifo_wr_en) + CW'(pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            credits  <= CRED_FULL;
            err      <= 1'b0;
        end else begin
            credits <= credits_next;
            if (fifo_pop && !pop_ok) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (fifo_wr_en) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (burst_end) begin
                            state  <= IDLE;
                            rr_ptr <= (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a behavioural reference model
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DWIDTH    = 16;
    localparam int DEPTH     = 8;
    localparam int MAX_BURST = 4;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_last;
    logic [NREQ*DWIDTH-1:0]   req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     fifo_wr_en;
    logic [DWIDTH-1:0]        fifo_din;
    logic                     fifo_pop;
    logic [$clog2(NREQ)-1:0]  grant_id;
    logic                     busy;
    logic [$clog2(DEPTH):0]   credits;
    logic                     err;

    int checks = 0;
    int errors = 0;

    int m_busy    = 0;
    int m_gid     = 0;
    int m_beats   = 0;
    int m_ptr     = 0;
    int m_credits = DEPTH;
    int m_err     = 0;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DWIDTH),
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_pop   (fifo_pop),
        .grant_id   (grant_id),
        .busy       (busy),
        .credits    (credits),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: evaluated mid-cycle, then advanced as the coming edge will
    always @(negedge clk) begin
        logic [NREQ-1:0] e_ready;
        logic            e_wr;
        int              pop_legal;
        if (!rstn) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_wr_en", fifo_wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_credits", credits, DEPTH);
            chk("rst_err", err, 0);
            chk("rst_grant", grant_id, 0);
            m_busy = 0; m_gid = 0; m_beats = 0; m_ptr = 0; m_credits = DEPTH; m_err = 0;
        end else begin
            e_ready = '0;
            if (m_busy != 0 && m_credits != 0) e_ready[m_gid] = 1'b1;
            e_wr = e_ready[m_gid] && req_valid[m_gid];
            chk("ready", req_ready, e_ready);
            chk("wr_en", fifo_wr_en, e_wr);
            chk("busy", busy, m_busy);
            chk("credits", credits, m_credits);
            chk("err", err, m_err);
            chk("grant_id", grant_id, m_gid);
            if (e_wr) chk("din", fifo_din, req_data[m_gid*DWIDTH +: DWIDTH]);

            pop_legal = (fifo_pop && m_credits < DEPTH) ? 1 : 0;
            if (fifo_pop && m_credits == DEPTH) m_err = 1;
            m_credits = m_credits - (e_wr ? 1 : 0) + pop_legal;

            if (m_busy == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_busy == 0 && req_valid[(m_ptr + k) % NREQ]) begin
                        m_gid   = (m_ptr + k) % NREQ;
                        m_beats = 0;
                        m_busy  = 1;
                    end
                end
            end else if (e_wr) begin
                m_beats++;
                if (req_last[m_gid] || m_beats == MAX_BURST) begin
                    m_busy = 0;
                    m_ptr  = (m_gid + 1) % NREQ;
                end
            end
        end
    end

    initial begin
        int rr_exp[4];
        int cap_exp[6];
        int n;
        rr_exp  = '{0, 2, 0, 2};
        cap_exp = '{1, 1, 1, 1, 0, 1};
        rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_pop = 1'b0;
        repeat (3) step();
        rstn = 1'b1;

        for (int c = 0; c < 10; c++) begin
            step();
            chk("def_credits", credits, 8);
            chk("def_busy", busy, 0);
            chk("def_ready", req_ready, 0);
            chk("def_err", err, 0);
        end

        req_data  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
        req_valid = 4'b0101;
        req_last  = 4'b0101;
        n = 0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            step();
            if (fifo_wr_en) begin
                chk("rr_grant", grant_id, rr_exp[n]);
                chk("rr_din", fifo_din, (rr_exp[n] == 0) ? 16'hA0A0 : 16'hC2C2);
                n++;
            end
        end
        chk("rr_count", n, 4);
        step();
        req_valid = '0; req_last = '0;
        chk("rr_credits", credits, 4);
        fifo_pop = 1'b1;
        repeat (4) step();
        fifo_pop = 1'b0;
        step();
        chk("refill_credits", credits, 8);

        req_valid = 4'b0010;
        for (int s = 0; s < 6; s++) begin
            step();
            chk("cap_wr", fifo_wr_en, cap_exp[s]);
        end
        chk("cap_grant", grant_id, 1);
        chk("cap_credits", credits, 4);
        step();
        chk("sim_pre_credits", credits, 3);
        chk("sim_pre_wr", fifo_wr_en, 1);
        fifo_pop = 1'b1;
        step();
        chk("sim_credits", credits, 3);
        fifo_pop = 1'b0;
        req_last = 4'b0010;
        step();
        chk("sim_end_credits", credits, 2);
        chk("sim_end_busy", busy, 0);
        req_valid = '0; req_last = '0;
        fifo_pop = 1'b1;
        repeat (6) step();
        fifo_pop = 1'b0;
        chk("refill2_credits", credits, 8);

        req_valid = 4'b0001;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (fifo_wr_en) n++;
        end
        chk("exh_writes", n, 8);
        chk("exh_credits", credits, 0);
        chk("exh_ready", req_ready, 0);
        chk("exh_busy", busy, 1);
        fifo_pop = 1'b1;
        step();
        fifo_pop = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (fifo_wr_en) n++;
            step();
        end
        chk("exh_one_more", n, 1);
        chk("exh_credits2", credits, 0);

        req_valid = '0;
        fifo_pop = 1'b1;
        repeat (8) step();
        chk("err_pre_credits", credits, 8);
        chk("err_pre_err", err, 0);
        step();
        fifo_pop = 1'b0;
        chk("err_credits", credits, 8);
        chk("err_set", err, 1);
        chk("err_busy_held", busy, 1);

        req_valid = 4'b0001;
        rstn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_wr", fifo_wr_en, 0);
        chk("arst_credits", credits, 8);
        chk("arst_err", err, 0);
        chk("arst_grant", grant_id, 0);
        step();
        step();
        rstn = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_last[i]  = ($urandom_range(0, 2) == 0);
                req_data[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
            end
            if (m_credits < DEPTH) fifo_pop = ($urandom_range(0, 1) == 1);
            else                   fifo_pop = ($urandom_range(0, 63) == 0);
            rstn = ($urandom_range(0, 499) != 0);
        end
        rstn = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo` write port among `NREQ` producers using valid/ready handshakes. A grant is held for a burst of beats, up to `MAX_BURST` or until the producer's `last` beat. The block tracks FIFO occupancy with its own credit counter, fed back from the consumer's pops, so it never issues a write into a full FIFO. It sits between the producer blocks and the FIFO's `wr_en`/`din` inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DWIDTH`, 16: data width; matches the FIFO.
- `DEPTH`, 8: FIFO depth; this is the initial credit count.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  per-requester beat valid.
- `req_last`  in  NREQ  marks the final beat of a burst.
- `req_data`  in  NREQ*DWIDTH  packed data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_ready`  out  NREQ  beat accepted when valid&&ready; at most one bit set.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_din`  out  DWIDTH  FIFO write data.
- `fifo_pop`  in  1  one pulse per entry the consumer actually removes (rd_en && !empty).
- `grant_id`  out  $clog2(NREQ)  index of the current or last grantee.
- `busy`  out  1  high in BURST.
- `credits`  out  $clog2(DEPTH)+1  free FIFO entries.
- `err`  out  1  sticky error: pop received while credits==DEPTH.

## Operation
States and transitions:
- **IDLE**
  - Priority scan starts at `rr_ptr`.
  - If any `req_valid` is high, latch the winner into `grant_id`, clear `beat_cnt`, and go to BURST.
  - No acceptance happens in IDLE.
- **BURST**
  - `req_ready[grant_id] = (credits != 0)`; all other ready bits are 0.
  - `fifo_wr_en = req_valid[grant_id] && req_ready[grant_id]`.
  - `fifo_din = req_data[grant_id]`; this path is combinational.
  - `beat_cnt` increments on each accepted beat.
  - An accepted beat with `req_last` set, or with `beat_cnt == MAX_BURST-1`, ends the burst:
    - next state is IDLE;
    - `rr_ptr <= grant_id+1`, wrapping modulo NREQ.
  - A requester that drops valid mid-burst keeps the grant; the arbiter waits indefinitely.

Credit counter:
- `credits_next = credits - fifo_wr_en + fifo_pop`, computed at full width.
- A simultaneous write and pop leaves `credits` unchanged.
- A pop at `credits == DEPTH` is ignored (saturates) and sets `err`.
- A write is impossible at `credits == 0` because ready is 0.
- The FIFO's own `full` is not used: it is registered and lags by one cycle.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0;
  - `credits` = DEPTH, `busy` 0, `err` 0;
  - `req_ready` 0, `fifo_wr_en` 0 (these follow state).
- Arbitration latency: a valid seen in IDLE at edge N gives `busy`/`req_ready` high after edge N; the first beat is written at edge N+1.
- One IDLE bubble cycle separates consecutive bursts.
- `credits` updates on the edge after the write or pop; ready reflects the registered value.
- Reset mid-burst:
  - the burst is abandoned and credits return to DEPTH;
  - the FIFO must be reset together with the arbiter.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - width helper localparams for the grant index, beat count and credit width.
- Sub-module `rr_pick`: a combinational rotating priority encoder.
  - Inputs: `req[NREQ]`, `start[$clog2(NREQ)]`.
  - Outputs: `gnt_idx`, `any`.
- Top level: FSM, beat counter, credit counter, data mux.

## Test plan
- **Reset defaults:** reset released, no requests → `credits`=8, `busy`=0, `req_ready`=0, `err`=0 for 10 cycles.
- **Round-robin rotation:** requesters 0 and 2 continuously valid, `req_last` on every beat → grants alternate 0,2,0,2; `fifo_din` tracks the granted requester's data.
- **Burst cap:** requester 1 holds valid with no `last`, MAX_BURST=4 → exactly 4 writes, one bubble cycle, then re-grant (requester 1 is the only one valid).
- **Credit exhaustion:** no pops, requester 0 streams 10 beats → 8 writes accepted, `credits`=0, ready low; one `fifo_pop` → exactly one further write the next cycle.
- **Simultaneous write and pop:** at `credits`=3, write and pop in the same cycle → `credits` stays 3.
- **Protocol error and reset:** a pop at `credits`=8 → `credits` stays 8 and `err`=1. Then assert `rstn` low mid-burst → outputs return to reset values asynchronously and `err` clears.
